// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the two-read / one-write register file.
// byte_merge works on a fixed maximum width so callers of any width can zero-extend into it.
package reg_file_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int NUM_REGS_DEF   = 32;
    localparam int ZERO_IDX_DEF   = 31;
    localparam int MAX_DATA_W     = 1024;
    localparam int MAX_BYTES      = MAX_DATA_W / 8;

    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_v,
        input logic [MAX_DATA_W-1:0] new_v,
        input logic [MAX_BYTES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_v;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (be[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_2r1w_en_reg.sv
// Enabled multi-bit register with asynchronous active-high clear.
module en_reg #(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] q_o,
    input  logic [WIDTH-1:0] d_i,
    input  logic             enable_i,
    input  logic             reset_i,
    input  logic             clk_i
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            q_o <= '0;
        end else if (enable_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file: two combinational read ports, one byte-strobed write port,
// optional hardwired-zero entry and optional same-cycle write-to-read bypass.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int NUM_REGS     = NUM_REGS_DEF,
    parameter int HAS_ZERO_REG = 1,
    parameter int ZERO_IDX     = ZERO_IDX_DEF,
    parameter int BYPASS       = 0,
    localparam int AW          = addr_width(NUM_REGS),
    localparam int NB          = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [NB-1:0]         wr_be_i,
    input  logic [AW-1:0]         rd_addr_a_i,
    input  logic [AW-1:0]         rd_addr_b_i,
    output logic [DATA_WIDTH-1:0] rd_data_a_o,
    output logic [DATA_WIDTH-1:0] rd_data_b_o
);

    if (HAS_ZERO_REG != 0 && ZERO_IDX >= NUM_REGS) begin : g_bad_zero_idx
        $error("reg_file_2r1w: ZERO_IDX must be below NUM_REGS");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_W) begin : g_bad_width
        $error("reg_file_2r1w: DATA_WIDTH must be a multiple of 8 and fit byte_merge");
    end

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] entry;
    logic                                wr_valid;
    logic [DATA_WIDTH-1:0]               rd_raw_a;
    logic [DATA_WIDTH-1:0]               rd_raw_b;

    // A write with no strobes, to a missing entry or to the zero entry changes nothing.
    assign wr_valid = wr_en_i && (|wr_be_i) && (int'(wr_addr_i) < NUM_REGS)
                      && !(HAS_ZERO_REG != 0 && int'(wr_addr_i) == ZERO_IDX);

    for (genvar e = 0; e < NUM_REGS; e++) begin : g_entry
        if (HAS_ZERO_REG != 0 && e == ZERO_IDX) begin : g_zero
            assign entry[e] = '0;
        end else begin : g_store
            for (genvar k = 0; k < NB; k++) begin : g_lane
                logic lane_en;
                assign lane_en = wr_valid && (wr_addr_i == AW'(e)) && wr_be_i[k];
                en_reg #(.WIDTH(8)) u_lane (
                    .q_o      (entry[e][8*k +: 8]),
                    .d_i      (wr_data_i[8*k +: 8]),
                    .enable_i (lane_en),
                    .reset_i  (reset_i),
                    .clk_i    (clk_i)
                );
            end
        end
    end

    always_comb begin
        rd_raw_a = '0;
        rd_raw_b = '0;
        if (int'(rd_addr_a_i) < NUM_REGS) rd_raw_a = entry[rd_addr_a_i];
        if (int'(rd_addr_b_i) < NUM_REGS) rd_raw_b = entry[rd_addr_b_i];
    end

    if (BYPASS != 0) begin : g_bypass
        logic [DATA_WIDTH-1:0] wr_cur;
        logic [DATA_WIDTH-1:0] wr_merged;

        always_comb begin
            wr_cur = '0;
            if (int'(wr_addr_i) < NUM_REGS) wr_cur = entry[wr_addr_i];
        end

        assign wr_merged = DATA_WIDTH'(byte_merge(MAX_DATA_W'(wr_cur),
                                                  MAX_DATA_W'(wr_data_i),
                                                  MAX_BYTES'(wr_be_i)));

        // Reset gating keeps both ports at zero while the array is being cleared.
        assign rd_data_a_o = (wr_valid && !reset_i && rd_addr_a_i == wr_addr_i) ? wr_merged : rd_raw_a;
        assign rd_data_b_o = (wr_valid && !reset_i && rd_addr_b_i == wr_addr_i) ? wr_merged : rd_raw_b;
    end else begin : g_direct
        assign rd_data_a_o = rd_raw_a;
        assign rd_data_b_o = rd_raw_b;
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: a default instance (BYPASS=0, zero at 31) and a 24-entry
// instance (BYPASS=1, zero at 0) share stimulus and are compared against array models.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic [4:0]  ra, rb;
    logic [63:0] a0, b0, a1, b1;

    int checks   = 0;
    int failures = 0;

    logic [63:0] m0 [32];
    logic [63:0] m1 [24];

    always #5 clk = ~clk;

    reg_file_2r1w u0 (
        .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_addr_a_i(ra), .rd_addr_b_i(rb),
        .rd_data_a_o(a0), .rd_data_b_o(b0)
    );

    reg_file_2r1w #(.NUM_REGS(24), .HAS_ZERO_REG(1), .ZERO_IDX(0), .BYPASS(1)) u1 (
        .clk_i(clk), .reset_i(reset), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .rd_addr_a_i(ra), .rd_addr_b_i(rb),
        .rd_data_a_o(a1), .rd_data_b_o(b1)
    );

    function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] be);
        logic [63:0] r = old_v;
        for (int k = 0; k < 8; k++) if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    // Instance 0: 32 entries, zero at 31, no bypass. Instance 1: 24 entries, zero at 0, bypass.
    function automatic logic [63:0] model_read(input int inst, input int addr);
        int n = (inst == 0) ? 32 : 24;
        int z = (inst == 0) ? 31 : 0;
        logic [63:0] v;
        if (addr >= n || addr == z) return 64'h0;
        v = (inst == 0) ? m0[addr] : m1[addr];
        if (inst == 1 && !reset && wr_en && wr_be != 8'h0 && addr == int'(wr_addr)
            && int'(wr_addr) < n && int'(wr_addr) != z)
            v = merge(v, wr_data, wr_be);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m0[i] = 64'h0;
        for (int i = 0; i < 24; i++) m1[i] = 64'h0;
    endtask

    task automatic model_commit();
        if (!reset && wr_en) begin
            if (wr_addr != 5'd31) m0[wr_addr] = merge(m0[wr_addr], wr_data, wr_be);
            if (wr_addr < 5'd24 && wr_addr != 5'd0) m1[wr_addr] = merge(m1[wr_addr], wr_data, wr_be);
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, "/a0"}, a0, model_read(0, int'(ra)));
        chk({tag, "/b0"}, b0, model_read(0, int'(rb)));
        chk({tag, "/a1"}, a1, model_read(1, int'(ra)));
        chk({tag, "/b1"}, b1, model_read(1, int'(rb)));
    endtask

    task automatic wr(input logic [4:0] addr, input logic [63:0] data, input logic [7:0] be);
        wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; ra = 5'd5; rb = 5'd0;
        model_reset();
        #2;
        check_all("reset_initial");
        reset = 1'b0;
        tick();

        // Asynchronous reset between edges clears a written entry immediately.
        wr(5'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        check_all("pre_reset_entry5");
        chk("entry5_written", a0, 64'hDEADBEEF_CAFEF00D);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset_a0", a0, 64'h0);
        chk("async_reset_a1", a1, 64'h0);
        for (int i = 0; i < 31; i++) begin
            ra = 5'(i);
            #1;
            chk("reset_all_entries", a0, 64'h0);
        end
        // A write held through an edge while in reset is lost.
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h55; wr_be = 8'hFF; ra = 5'd6;
        tick();
        wr_en = 1'b0;
        check_all("write_during_reset");
        reset = 1'b0;
        tick();

        // Full writes and dual reads.
        wr(5'd3, 64'h1111, 8'hFF);
        wr(5'd7, 64'h2222, 8'hFF);
        ra = 5'd3; rb = 5'd7;
        check_all("dual_read");
        chk("dual_read_a_const", a0, 64'h1111);
        chk("dual_read_b_const", b0, 64'h2222);
        ra = 5'd7;
        check_all("same_entry");

        // Byte strobes.
        wr(5'd2, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
        wr(5'd2, 64'h0, 8'h0F);
        ra = 5'd2;
        check_all("byte_strobe");
        chk("byte_strobe_const", a0, 64'hFFFFFFFF_00000000);

        // Zero entries and out-of-range addresses.
        wr(5'd31, 64'h1234, 8'hFF);
        wr(5'd0, 64'h5678, 8'hFF);
        wr(5'd28, 64'h9ABC, 8'hFF);
        ra = 5'd31; rb = 5'd0;
        check_all("zero_regs");
        ra = 5'd28; rb = 5'd3;
        check_all("out_of_range");
        chk("oor_const_inst1", a1, 64'h0);

        // Bypass behaviour.
        wr(5'd4, 64'hAA, 8'hFF);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'hBB; wr_be = 8'hFF; ra = 5'd4; rb = 5'd4;
        check_all("bypass_before_edge");
        chk("no_bypass_old", a0, 64'hAA);
        chk("bypass_new", a1, 64'hBB);
        wr_be = 8'h00;
        check_all("bypass_no_strobe");
        chk("bypass_no_strobe_const", a1, 64'hAA);
        wr_be = 8'hFF;
        tick();
        wr_en = 1'b0;
        check_all("after_edge");
        chk("no_bypass_after_edge", a0, 64'hBB);

        // Random traffic with occasional reset.
        for (int i = 0; i < 1000; i++) begin
            reset = ($urandom_range(63) == 0);
            if (reset) model_reset();
            wr_en   = ($urandom_range(3) != 0);
            wr_addr = 5'($urandom_range(31));
            wr_data = {$urandom, $urandom};
            wr_be   = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            ra = ($urandom_range(2) == 0) ? wr_addr : 5'($urandom_range(31));
            rb = ($urandom_range(2) == 0) ? wr_addr : 5'($urandom_range(31));
            check_all("random");
            tick();
        end
        reset = 1'b0;
        wr_en = 1'b0;
        check_all("random_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
